divider_seq: RTL and testbench

Sequential restoring divider that undoes the product written by the registered multiplier. It takes a 2*BITWIDTH-bit dividend and a BITWIDTH-bit divisor. It produces a 2*BITWIDTH-bit quotient and a BITWIDTH-bit remainder, computing one quotient bit per clock. It sits on the same datapath as the multiplier, for example to recover an operand or to normalise an accumulated product, and uses a start/busy/done handshake.

---
 rtl/divider_seq_pkg.sv | 17 +
 rtl/divider_step.sv | 24 ++
 rtl/divider_seq.sv | 151 +++++++++++++++
 tb/tb_divider_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential restoring divider: operand width,
// state encodings and iteration-counter width.
package divider_seq_pkg;

  localparam int BITWIDTH = 8;
  localparam int DW       = 2 * BITWIDTH;
  localparam int CNT_W    = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW - 1);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module divider_step
  import divider_seq_pkg::*;
(
  input  logic [BITWIDTH:0]   rem_i,
  input  logic                bit_i,
  input  logic [BITWIDTH-1:0] div_i,
  output logic [BITWIDTH:0]   rem_o,
  output logic                q_o
);

  logic [BITWIDTH+1:0] shifted;
  logic [BITWIDTH+1:0] diff;

  // The extra top bit only matters for a zero divisor, where it is discarded.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, div_i};
    q_o     = (shifted >= {2'b00, div_i});
    rem_o   = (BITWIDTH + 1)'(q_o ? diff : shifted);
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done
// handshake. Optional DIVIDER_SEQ_DIVZERO_EN adds a zero-divisor fast path and flag.
//
// state | meaning
// IDLE  | waiting for iStart; operands captured on accept
// RUN   | one restoring iteration per cycle, counter counts down to 0
// DONE  | oDone pulse, results valid; returns to IDLE
module divider_seq
  import divider_seq_pkg::*;
(
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic [DW-1:0]       iDividend,
  input  logic [BITWIDTH-1:0] iDivisor,
  output logic                oBusy,
  output logic                oDone,
  output logic [DW-1:0]       oQuotient,
  output logic [BITWIDTH-1:0] oRemainder
`ifdef DIVIDER_SEQ_DIVZERO_EN
  ,
  output logic                oDivZero
`endif
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       dvd_q, dvd_d;
  logic [BITWIDTH-1:0] div_q, div_d;
  logic [BITWIDTH:0]   rem_q, rem_d;
  logic [DW-1:0]       quot_q, quot_d;
  logic [BITWIDTH-1:0] remo_q, remo_d;

  logic [BITWIDTH:0]   step_rem;
  logic                step_q;

`ifdef DIVIDER_SEQ_DIVZERO_EN
  logic dz_q, dz_d;
  logic dzflag_q, dzflag_d;
`endif

  divider_step u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DW-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      remo_q   <= '0;
`ifdef DIVIDER_SEQ_DIVZERO_EN
      dz_q     <= 1'b0;
      dzflag_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
`ifdef DIVIDER_SEQ_DIVZERO_EN
      dz_q     <= dz_d;
      dzflag_q <= dzflag_d;
`endif
    end
  end

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
`ifdef DIVIDER_SEQ_DIVZERO_EN
    dz_d     = dz_q;
    dzflag_d = dzflag_q;
`endif
    if (iClr) begin
      state_d  = IDLE;
      quot_d   = '0;
      remo_d   = '0;
`ifdef DIVIDER_SEQ_DIVZERO_EN
      dzflag_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            dvd_d   = iDividend;
            div_d   = iDivisor;
            rem_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = RUN;
`ifdef DIVIDER_SEQ_DIVZERO_EN
            dz_d    = (iDivisor == '0);
`endif
          end
        end
        RUN: begin
`ifdef DIVIDER_SEQ_DIVZERO_EN
          if (dz_q) begin
            quot_d   = '1;
            remo_d   = dvd_q[BITWIDTH-1:0];
            dzflag_d = 1'b1;
            state_d  = DONE;
          end else
`endif
          begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DW-2:0], step_q};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
              quot_d  = {dvd_q[DW-2:0], step_q};
              remo_d  = step_rem[BITWIDTH-1:0];
              state_d = DONE;
`ifdef DIVIDER_SEQ_DIVZERO_EN
              dzflag_d = 1'b0;
`endif
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign oBusy      = (state_q != IDLE);
  assign oDone      = (state_q == DONE);
  assign oQuotient  = quot_q;
  assign oRemainder = remo_q;
`ifdef DIVIDER_SEQ_DIVZERO_EN
  assign oDivZero   = dzflag_q;
`endif

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: arithmetic/schedule model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_divider_seq;

  localparam int W  = 8;
  localparam int DW = 16;
`ifdef DIVIDER_SEQ_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          iRstN = 1'b1;
  logic          iClr = 1'b0;
  logic          iStart = 1'b0;
  logic [DW-1:0] iDividend = '0;
  logic [W-1:0]  iDivisor = '0;
  logic          oBusy, oDone;
  logic [DW-1:0] oQuotient;
  logic [W-1:0]  oRemainder;
`ifdef DIVIDER_SEQ_DIVZERO_EN
  logic          oDivZero;
`endif

  divider_seq dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iClr       (iClr),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder)
`ifdef DIVIDER_SEQ_DIVZERO_EN
    ,
    .oDivZero   (oDivZero)
`endif
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since accepted start (0 = idle), latency to the done cycle,
  // and published results computed with plain / and %.
  int            m_k = 0;
  int            m_lat = 17;
  logic [DW-1:0] m_q = '0, p_q = '0;
  logic [W-1:0]  m_r = '0, p_r = '0;
  logic          m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      m_k = 0; m_lat = 17; m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (iClr) begin
      m_k = 0; m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (m_k == 0) begin
      if (iStart) begin
        if (iDivisor == '0) begin
          p_q = '1; p_r = iDividend[W-1:0]; p_dz = DZ_EN;
          m_lat = DZ_EN ? 2 : 17;
        end else begin
          p_q = DW'(iDividend / iDivisor); p_r = W'(iDividend % iDivisor); p_dz = 1'b0;
          m_lat = 17;
        end
        m_k = 1;
      end
    end else if (m_k == m_lat) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == m_lat) begin m_q = p_q; m_r = p_r; m_dz = p_dz; end
    end
  end

  always @(negedge iClk) begin
    check("busy", 32'(oBusy), 32'(m_k != 0));
    check("done", 32'(oDone), 32'(m_k != 0 && m_k == m_lat));
    check("quotient", 32'(oQuotient), 32'(m_q));
    check("remainder", 32'(oRemainder), 32'(m_r));
`ifdef DIVIDER_SEQ_DIVZERO_EN
    check("divzero", 32'(oDivZero), 32'(m_dz));
`endif
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one start at the next negedge; optionally poke a bogus start mid-run.
  task automatic run_op(input logic [DW-1:0] dvd, input logic [W-1:0] dvs, input int poke_at,
                        output logic [DW-1:0] q, output logic [W-1:0] r,
                        output int lat, output int bcnt);
    int n;
    @(negedge iClk);
    iStart = 1'b1; iDividend = dvd; iDivisor = dvs;
    @(negedge iClk);
    iStart = 1'b0;
    n = 1;
    bcnt = oBusy ? 1 : 0;
    while (!oDone && n < 40) begin
      @(negedge iClk);
      n++;
      if (oBusy) bcnt++;
      if (n == poke_at) begin
        iStart = 1'b1; iDividend = 16'd12345; iDivisor = 8'd3;
      end else begin
        iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    if (!oDone) begin
      total++; bad++;
      $display("FAIL done_timeout: got no oDone after %0d cycles expected oDone", n);
    end
    q = oQuotient; r = oRemainder; lat = n - 1;
  endtask

  logic [DW-1:0] q, rdvd;
  logic [W-1:0]  r, rdvs;
  int lat, bcnt, seen;

  initial begin
    #1 iRstN = 1'b0;
    repeat (2) @(negedge iClk);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_done", 32'(oDone), 0);
    check("rst_q", 32'(oQuotient), 0);
    check("rst_r", 32'(oRemainder), 0);
    iRstN = 1'b1;

    run_op(16'd1000, 8'd7, 0, q, r, lat, bcnt);
    check("t1_lat", 32'(lat), 16);
    check("t1_busy_cycles", 32'(bcnt), 17);
    check("t1_q", 32'(q), 142);
    check("t1_r", 32'(r), 6);

    run_op(16'd65535, 8'd255, 0, q, r, lat, bcnt);
    check("t2_q", 32'(q), 257);
    check("t2_r", 32'(r), 0);
    run_op(16'd143, 8'd11, 0, q, r, lat, bcnt);
    check("t3_q", 32'(q), 13);
    check("t3_r", 32'(r), 0);
    check("t3_lat", 32'(lat), 16);

    run_op(16'd40000, 8'd9, 5, q, r, lat, bcnt);
    check("ign_q", 32'(q), 4444);
    check("ign_r", 32'(r), 4);
    check("ign_lat", 32'(lat), 16);

    @(negedge iClk);
    iStart = 1'b1; iDividend = 16'd1000; iDivisor = 8'd7;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (4) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    check("clr_busy", 32'(oBusy), 0);
    check("clr_q", 32'(oQuotient), 0);
    check("clr_r", 32'(oRemainder), 0);
    seen = 0;
    repeat (20) begin
      @(negedge iClk);
      if (oDone) seen = 1;
    end
    check("clr_no_done", 32'(seen), 0);
    run_op(16'd1000, 8'd7, 0, q, r, lat, bcnt);
    check("clr_fresh_q", 32'(q), 142);
    check("clr_fresh_r", 32'(r), 6);

    @(negedge iClk);
    iClr = 1'b1; iStart = 1'b1; iDividend = 16'd77; iDivisor = 8'd2;
    @(negedge iClk);
    iClr = 1'b0; iStart = 1'b0;
    check("clr_start_busy", 32'(oBusy), 0);
    @(negedge iClk);
    check("clr_start_busy2", 32'(oBusy), 0);

    run_op(16'd100, 8'd3, 0, q, r, lat, bcnt);
    check("pre_rst_q", 32'(q), 33);
    @(negedge iClk);
    iStart = 1'b1; iDividend = 16'd500; iDivisor = 8'd7;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (3) @(negedge iClk);
    #2 iRstN = 1'b0;
    #1;
    check("mrst_busy", 32'(oBusy), 0);
    check("mrst_q", 32'(oQuotient), 0);
    check("mrst_r", 32'(oRemainder), 0);
    @(negedge iClk);
    iRstN = 1'b1;
    run_op(16'd143, 8'd11, 0, q, r, lat, bcnt);
    check("mrst_fresh_q", 32'(q), 13);
    check("mrst_fresh_r", 32'(r), 0);

    run_op(16'd500, 8'd0, 0, q, r, lat, bcnt);
    check("dz_q", 32'(q), 32'hFFFF);
    check("dz_r", 32'(r), 32'hF4);
    check("dz_lat", 32'(lat), DZ_EN ? 1 : 16);
`ifdef DIVIDER_SEQ_DIVZERO_EN
    check("dz_flag", 32'(oDivZero), 1);
`endif
    run_op(16'd10, 8'd3, 0, q, r, lat, bcnt);
    check("after_dz_q", 32'(q), 3);
    check("after_dz_r", 32'(r), 1);
`ifdef DIVIDER_SEQ_DIVZERO_EN
    check("after_dz_flag", 32'(oDivZero), 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      rdvd = DW'($urandom_range(0, 65535));
      rdvs = W'($urandom_range(1, 255));
      run_op(rdvd, rdvs, 0, q, r, lat, bcnt);
      check("rnd_identity", 32'(q) * 32'(rdvs) + 32'(r), 32'(rdvd));
      check("rnd_rem_lt_div", 32'(r < rdvs), 1);
    end

    @(negedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
